// File: rtl/slicevm_ctrl.sv
// slicevm_ctrl: sequencer for the SVM slice accumulator.
// Holds the SVM coefficient RAM, retimes the incoming feature stream, and
// drives dvi/data/svcoeff/newblock into the slice. The block and word
// counters stay in step with the slice's own block counter. At end of
// frame it runs a fixed-length download phase that drains the slice's
// window FIFO.
//
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   cfg_we/addr/data      coefficient RAM write port (honoured in IDLE only)
//   in_fv, in_dv, in_data frame valid, word valid, feature word
//   dvi, data, svcoeff    retimed word and its coefficient to the slice
//   newblock              last word of a block, only ever high with dvi
//   download              slice drain/clear, high for WPI cycles
//   busy                  FSM outside IDLE
//   frame_done            one-cycle pulse after the drain
//   cfg_err, ovf          sticky error flags
//
// state | meaning
// IDLE  | waiting for frame start; coefficient writes accepted
// RUN   | streaming words into the slice
// FLUSH | download asserted for WPI cycles, counters cleared
// DONE  | frame_done pulse, then back to IDLE
module slicevm_ctrl #(
  parameter int DWIDTH    = 8,
  parameter int CWIDTH    = 9,
  parameter int BLOCKSIZE = 32,
  parameter int WINCOLS   = 8,
  parameter int WPI       = 40,
  parameter int AWIDTH    = $clog2(BLOCKSIZE*WINCOLS)
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cfg_we,
  input  logic [AWIDTH-1:0] cfg_addr,
  input  logic [CWIDTH-1:0] cfg_data,
  input  logic              in_fv,
  input  logic              in_dv,
  input  logic [DWIDTH-1:0] in_data,
  output logic              dvi,
  output logic [DWIDTH-1:0] data,
  output logic [CWIDTH-1:0] svcoeff,
  output logic              newblock,
  output logic              download,
  output logic              busy,
  output logic              frame_done,
  output logic              cfg_err,
  output logic              ovf
);

  localparam int WW = $clog2(BLOCKSIZE);
  localparam int BW = $clog2(WINCOLS);
  localparam int TW = $clog2(WPI);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

  state_t            state_q, state_d;
  logic [TW-1:0]     tmr_q, tmr_d;
  logic [WW-1:0]     wcnt_q, wcnt_d;
  logic [BW-1:0]     bcnt_q, bcnt_d;
  logic              fv_q;
  logic              pend_q, pend_d;
  logic              dvi_q, dvi_d;
  logic              newblock_q, newblock_d;
  logic [DWIDTH-1:0] data_q, data_d;
  logic [CWIDTH-1:0] svcoeff_q, svcoeff_d;
  logic              cfg_err_q, cfg_err_d;
  logic              ovf_q, ovf_d;

  logic [CWIDTH-1:0] ram_mem [BLOCKSIZE*WINCOLS];
  logic [AWIDTH-1:0] raddr;
  logic              ram_we;
  logic              rd_en;
  logic              fv_rise, fv_fall;
  logic              wlast;

  assign fv_rise = in_fv & ~fv_q;
  assign fv_fall = ~in_fv & fv_q;
  assign wlast   = (wcnt_q == WW'(BLOCKSIZE-1));
  // Power-of-two sizes make bcnt*BLOCKSIZE + wcnt a plain concatenation.
  assign raddr   = {bcnt_q, wcnt_q};
  assign rd_en   = (state_q == S_RUN) & in_dv;
  assign ram_we  = cfg_we & (state_q == S_IDLE);

  always_comb begin
    state_d    = state_q;
    tmr_d      = tmr_q;
    wcnt_d     = wcnt_q;
    bcnt_d     = bcnt_q;
    pend_d     = pend_q;
    dvi_d      = rd_en;
    newblock_d = rd_en & wlast;
    data_d     = rd_en ? in_data : data_q;
    svcoeff_d  = rd_en ? ram_mem[raddr] : svcoeff_q;
    cfg_err_d  = cfg_err_q | (cfg_we & (state_q != S_IDLE));
    ovf_d      = ovf_q | ((state_q == S_FLUSH) & in_dv);
    case (state_q)
      S_IDLE: begin
        pend_d = 1'b0;
        // A rise seen during FLUSH/DONE starts a frame once back here,
        // provided in_fv is still high.
        if (fv_rise || (pend_q && in_fv)) state_d = S_RUN;
      end
      S_RUN: begin
        if (in_dv) begin
          wcnt_d = wcnt_q + WW'(1);
          if (wlast) bcnt_d = bcnt_q + BW'(1);
        end
        if (fv_fall) begin
          state_d = S_FLUSH;
          tmr_d   = TW'(WPI-1);
          wcnt_d  = '0;
          bcnt_d  = '0;
        end
      end
      S_FLUSH: begin
        if (fv_rise) pend_d = 1'b1;
        if (tmr_q == '0) state_d = S_DONE;
        else             tmr_d   = tmr_q - TW'(1);
      end
      S_DONE: begin
        if (fv_rise) pend_d = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= S_IDLE;
      tmr_q      <= '0;
      wcnt_q     <= '0;
      bcnt_q     <= '0;
      fv_q       <= 1'b0;
      pend_q     <= 1'b0;
      dvi_q      <= 1'b0;
      newblock_q <= 1'b0;
      data_q     <= '0;
      svcoeff_q  <= '0;
      cfg_err_q  <= 1'b0;
      ovf_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      tmr_q      <= tmr_d;
      wcnt_q     <= wcnt_d;
      bcnt_q     <= bcnt_d;
      fv_q       <= in_fv;
      pend_q     <= pend_d;
      dvi_q      <= dvi_d;
      newblock_q <= newblock_d;
      data_q     <= data_d;
      svcoeff_q  <= svcoeff_d;
      cfg_err_q  <= cfg_err_d;
      ovf_q      <= ovf_d;
    end
  end

  // Coefficient storage is not reset.
  always_ff @(posedge clk) begin
    if (ram_we) ram_mem[cfg_addr] <= cfg_data;
  end

  assign dvi        = dvi_q;
  assign data       = data_q;
  assign svcoeff    = svcoeff_q;
  assign newblock   = newblock_q;
  assign download   = (state_q == S_FLUSH);
  assign busy       = (state_q != S_IDLE);
  assign frame_done = (state_q == S_DONE);
  assign cfg_err    = cfg_err_q;
  assign ovf        = ovf_q;

endmodule

// File: tb/tb_slicevm_ctrl.sv
module tb_slicevm_ctrl;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       cfg_we = 1'b0;
  logic [7:0] cfg_addr = '0;
  logic [8:0] cfg_data = '0;
  logic       in_fv = 1'b0;
  logic       in_dv = 1'b0;
  logic [7:0] in_data = '0;
  logic       dvi;
  logic [7:0] data;
  logic [8:0] svcoeff;
  logic       newblock, download, busy, frame_done, cfg_err, ovf;

  int checks = 0;
  int failures = 0;

  slicevm_ctrl dut (
    .clk(clk), .reset_n(reset_n),
    .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
    .in_fv(in_fv), .in_dv(in_dv), .in_data(in_data),
    .dvi(dvi), .data(data), .svcoeff(svcoeff), .newblock(newblock),
    .download(download), .busy(busy), .frame_done(frame_done),
    .cfg_err(cfg_err), .ovf(ovf)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Inputs change and outputs are sampled 1 time unit after the rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_idle_outputs(input string tag);
    chk({tag, "_dvi"}, dvi, 0);
    chk({tag, "_data"}, data, 0);
    chk({tag, "_svc"}, svcoeff, 0);
    chk({tag, "_nb"}, newblock, 0);
    chk({tag, "_dl"}, download, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_fd"}, frame_done, 0);
    chk({tag, "_cerr"}, cfg_err, 0);
    chk({tag, "_ovf"}, ovf, 0);
  endtask

  function automatic logic [8:0] coef(input int a);
    logic [7:0] b;
    b = a[7:0];
    return {b[7], b};
  endfunction

  // Starts a frame and streams nwords words with gap idle cycles after each.
  task automatic stream(input int nwords, input int gap);
    logic [8:0] last_c;
    logic [7:0] last_d;
    in_fv = 1'b1;
    step();
    step();
    chk("busy_run", busy, 1);
    last_c = svcoeff;
    last_d = data;
    for (int w = 0; w < nwords; w++) begin
      for (int g = 0; g <= gap; g++) begin
        in_dv = (g == 0);
        in_data = 8'(w * 7 + 3);
        step();
        in_dv = 1'b0;
        if (g == 0) begin
          last_c = coef(w);
          last_d = 8'(w * 7 + 3);
          chk("dvi_word", dvi, 1);
          chk("data", data, last_d);
          chk("svcoeff", svcoeff, last_c);
          chk("newblock", newblock, (w % 32) == 31);
        end else begin
          chk("dvi_gap", dvi, 0);
          chk("nb_gap", newblock, 0);
          chk("svc_hold", svcoeff, last_c);
          chk("data_hold", data, last_d);
        end
      end
    end
    in_dv = 1'b0;
    step();
    chk("dvi_tail", dvi, 0);
  endtask

  // Drops in_fv and measures the drain; optionally pokes in_dv in FLUSH.
  task automatic finish_frame(input bit poke);
    int cnt;
    in_fv = 1'b0;
    step();
    cnt = 0;
    while (download && cnt < 100) begin
      cnt++;
      chk("flush_dvi", dvi, 0);
      chk("flush_nb", newblock, 0);
      chk("flush_fd", frame_done, 0);
      in_dv = poke && (cnt == 3);
      step();
      in_dv = 1'b0;
    end
    chk("flush_len", cnt, 40);
    chk("done_pulse", frame_done, 1);
    chk("done_busy", busy, 1);
    step();
    chk("done_clear", frame_done, 0);
    chk("busy_clear", busy, 0);
    if (poke) chk("ovf_set", ovf, 1);
  endtask

  initial begin
    #1;
    chk_idle_outputs("reset");
    step();
    reset_n = 1'b1;
    step();
    chk_idle_outputs("post_reset");

    for (int a = 0; a < 256; a++) begin
      cfg_we = 1'b1;
      cfg_addr = 8'(a);
      cfg_data = coef(a);
      step();
    end
    cfg_we = 1'b0;
    chk("cfg_err_idle", cfg_err, 0);

    // Back-to-back full window, then gapped stream, then a bcnt wrap.
    stream(256, 0);
    finish_frame(1'b0);
    stream(64, 2);
    finish_frame(1'b0);
    stream(512, 0);
    finish_frame(1'b0);

    // Partial frame; the next frame must restart at address 0.
    stream(40, 0);
    finish_frame(1'b1);
    stream(4, 0);
    cfg_we = 1'b1;
    cfg_addr = 8'd0;
    cfg_data = 9'h0AA;
    step();
    cfg_we = 1'b0;
    chk("cfg_err_run", cfg_err, 1);
    finish_frame(1'b0);
    stream(2, 0);
    finish_frame(1'b0);
    chk("cfg_err_sticky", cfg_err, 1);
    chk("ovf_sticky", ovf, 1);

    // Reset mid-RUN.
    stream(10, 0);
    reset_n = 1'b0;
    #1;
    chk("rst_run_busy", busy, 0);
    chk("rst_run_svc", svcoeff, 0);
    in_fv = 1'b0;
    step();
    reset_n = 1'b1;
    step();
    chk_idle_outputs("rst_run");

    // Reset mid-FLUSH: download must drop without waiting for a clock.
    stream(5, 0);
    in_fv = 1'b0;
    step();
    step();
    chk("dl_before_rst", download, 1);
    reset_n = 1'b0;
    #1;
    chk("dl_async_clear", download, 0);
    step();
    reset_n = 1'b1;
    step();
    chk_idle_outputs("rst_flush");

    stream(33, 0);
    finish_frame(1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    failures++;
    $display("FAIL timeout got=running exp=finished");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $fatal(1, "timeout");
  end

endmodule
